ppu_palette_ram: RTL

- Palette memory: the responder on the PPU VRAM read bus for the palette window $3F00-$3FFF.
- Serves palette-load reads with 1-cycle registered latency: data presented in cycle N+1 belongs to the address in cycle N.
- Accepts CPU-side palette writes from the PPUDATA path.
- Raises a level reload request so the palette loader refreshes its cached colours after any change.

---
 rtl/ppu_pal_pkg.sv | 26 ++
 rtl/ppu_palette_mirror.sv | 25 ++
 rtl/ppu_palette_ram.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ppu_pal_pkg.sv
// Shared constants, state encoding and power-up colours for the PPU palette RAM.
// The default palette is only consumed when PALETTE_INIT_EN is defined.
package ppu_pal_pkg;

    localparam int         PAL_ENTRIES = 32;
    localparam int         DATA_W      = 6;
    localparam logic [5:0] PAL_PAGE    = 6'h3F;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } pal_state_e;

    // Entry 0 sits in the least significant 6 bits, entry 31 in the most significant.
    localparam logic [PAL_ENTRIES*6-1:0] DEFAULT_PALETTE = {
        6'h08, 6'h2C, 6'h20, 6'h00, 6'h02, 6'h00, 6'h3A, 6'h08,
        6'h14, 6'h00, 6'h04, 6'h00, 6'h03, 6'h34, 6'h01, 6'h09,
        6'h2C, 6'h04, 6'h00, 6'h00, 6'h24, 6'h08, 6'h10, 6'h08,
        6'h0D, 6'h02, 6'h02, 6'h00, 6'h01, 6'h00, 6'h01, 6'h09
    };

    function automatic logic [5:0] default_colour(input logic [4:0] k);
        return DEFAULT_PALETTE[k*6 +: 6];
    endfunction

endpackage

// File: rtl/ppu_palette_mirror.sv
// Palette window decode and index fold for one address port.
// The sprite backdrop slots $10/$14/$18/$1C alias the background slots $00/$04/$08/$0C.
module ppu_palette_mirror
    import ppu_pal_pkg::*;
(
    input  logic [15:0] addr,
    output logic        in_window,
    output logic [4:0]  idx
);

    // Upper mirror bits and the intra-page repeat bits do not affect decoding.
    logic [4:0] unused_addr;
    assign unused_addr = {addr[15:14], addr[7:5]};

    assign in_window = (addr[13:8] == PAL_PAGE);

    // Fold the sprite backdrop entries onto their background counterparts.
    always_comb begin
        idx = addr[4:0];
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            idx[4] = 1'b0;
        end
    end

endmodule

// File: rtl/ppu_palette_ram.sv
// PPU palette memory: answers VRAM bus reads in the $3F00-$3FFF window with one
// cycle of latency, takes PPUDATA writes, and asks the loader to refresh after changes.
// Optional macro PALETTE_INIT_EN adds a 32-cycle power-up sweep of the default palette.
module ppu_palette_ram
    import ppu_pal_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] vram_addr,
    output logic [7:0]  vram_data_out,
    output logic        vram_hit,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        init_busy,
    output logic        reload_req,
    input  logic        reload_ack
);

    logic                rd_in_win;
    logic [4:0]          rd_idx;
    logic                wr_in_win;
    logic [4:0]          wr_idx;
    logic [DATA_W-1:0]   mem [PAL_ENTRIES];
    logic                wr_accept;
    logic                rd_forward;
    logic                init_done;
    logic [7:0]          rd_word;

    // Colour values are only 6 bits wide; the top bits of the write data are dropped.
    logic [7-DATA_W:0]   unused_wr_bits;
    assign unused_wr_bits = wr_data[7:DATA_W];

    ppu_palette_mirror u_rd_mirror (
        .addr      (vram_addr),
        .in_window (rd_in_win),
        .idx       (rd_idx)
    );

    ppu_palette_mirror u_wr_mirror (
        .addr      (wr_addr),
        .in_window (wr_in_win),
        .idx       (wr_idx)
    );

`ifdef PALETTE_INIT_EN
    pal_state_e state;
    pal_state_e state_next;
    logic [4:0] init_cnt;

    // State register; every reset restarts the power-up sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Leave INIT once the last entry has been written; READY is terminal.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (init_cnt == 5'd31) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_READY;
        endcase
    end

    // Sweep counter selects which entry receives its default colour this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= 5'd0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 5'd1;
        end
    end

    assign init_busy = (state == ST_INIT);
    assign init_done = init_busy && (init_cnt == 5'd31);
`else
    assign init_busy = 1'b0;
    assign init_done = 1'b0;
`endif

    assign wr_accept  = wr_en && wr_in_win && !init_busy;
    assign rd_forward = wr_accept && (wr_idx == rd_idx);

    // Palette storage: sweep writes during INIT, CPU writes once READY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else begin
`ifdef PALETTE_INIT_EN
            if (init_busy) begin
                mem[init_cnt] <= default_colour(init_cnt);
            end
`endif
            if (wr_accept) begin
                mem[wr_idx] <= wr_data[DATA_W-1:0];
            end
        end
    end

    // Select read data, forwarding a same-cycle write so the loader never sees stale colour.
    always_comb begin
        rd_word = 8'h00;
        if (rd_in_win) begin
            if (rd_forward) begin
                rd_word = 8'(wr_data[DATA_W-1:0]);
            end else begin
                rd_word = 8'(mem[rd_idx]);
            end
        end
    end

    // Register the read response so data lands exactly one cycle after its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vram_data_out <= 8'h00;
            vram_hit      <= 1'b0;
        end else begin
            vram_data_out <= rd_word;
            vram_hit      <= rd_in_win;
        end
    end

    // Reload request: a fresh change outranks a simultaneous acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_req <= 1'b0;
        end else if (wr_accept || init_done) begin
            reload_req <= 1'b1;
        end else if (reload_ack) begin
            reload_req <= 1'b0;
        end
    end

endmodule
